div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 35 +++
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative divider: the operand width, the
// quotient returned when the divisor is zero, and the controller states.
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DATA_W = 32;

    // Quotient reported for a divide by zero (all ones, like RISC-V DIV/DIVU).
    localparam logic [DATA_W-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    // IDLE    : waiting for a request
    // DIVZERO : one-cycle detour that skips the iteration for op2 == 0
    // ON      : one restoring step per clock
    // END     : result valid, ready pulse
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One radix-2 restoring division step, purely combinational.
//   i_rem : partial remainder before the step
//   i_quo : dividend bits still to shift in (MSB first) / quotient so far
//   i_div : divisor magnitude
//   o_rem : partial remainder after the step
//   o_quo : i_quo shifted left with the new quotient bit in the LSB
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
(
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_quo,
    input  logic [DATA_W-1:0] i_div,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_quo
);

    logic [DATA_W:0] w_shift;
    logic [DATA_W:0] w_trial;
    logic            w_fits;

    // The shifted remainder is below 2*divisor, so a DATA_W+1 bit subtract
    // is enough: its top bit is set exactly when the difference is negative.
    assign w_shift = {i_rem, i_quo[DATA_W-1]};
    assign w_trial = w_shift - {1'b0, i_div};
    assign w_fits  = ~w_trial[DATA_W];

    // A kept difference is always below the divisor, and a rejected shift
    // is below the divisor too, so both fit back into DATA_W bits.
    assign o_rem = w_fits ? w_trial[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign o_quo = {i_quo[DATA_W-2:0], w_fits};

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative 32-bit signed/unsigned divider, one quotient bit per clock.
//   clk          : clock, rising edge
//   resetn       : synchronous active-low reset
//   div_sign     : 1 = signed operands, 0 = unsigned (sampled with start)
//   div_start_i  : request a divide (only taken in IDLE)
//   div_annul_i  : abort the operation in flight / block a start in IDLE
//   div_op1      : dividend
//   div_op2      : divisor
//   result       : {remainder, quotient}, held until the next completion
//   div_ready_o  : one-cycle pulse while result is freshly valid
//   div_busy_o   : high in every state except IDLE
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                div_sign,
    input  logic                div_start_i,
    input  logic                div_annul_i,
    input  logic [DATA_W-1:0]   div_op1,
    input  logic [DATA_W-1:0]   div_op2,
    output logic [2*DATA_W-1:0] result,
    output logic                div_ready_o,
    output logic                div_busy_o
);

    import div_pkg::*;

    localparam int               CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    div_state_t          r_state;
    logic [CNT_W-1:0]    r_count;
    logic [DATA_W-1:0]   r_rem;
    logic [DATA_W-1:0]   r_quo;
    logic [DATA_W-1:0]   r_div;
    logic                r_sign;
    logic                r_neg1;
    logic                r_neg2;
    logic [2*DATA_W-1:0] r_result;

    logic                w_neg1;
    logic                w_neg2;
    logic [DATA_W-1:0]   w_mag1;
    logic [DATA_W-1:0]   w_mag2;
    logic [DATA_W-1:0]   w_rem_next;
    logic [DATA_W-1:0]   w_quo_next;
    logic [DATA_W-1:0]   w_quo_fix;
    logic [DATA_W-1:0]   w_rem_fix;

    // Operand magnitudes; negation only applies to negative signed values.
    assign w_neg1 = div_sign & div_op1[DATA_W-1];
    assign w_neg2 = div_sign & div_op2[DATA_W-1];
    assign w_mag1 = w_neg1 ? -div_op1 : div_op1;
    assign w_mag2 = w_neg2 ? -div_op2 : div_op2;

    div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_next),
        .o_quo (w_quo_next)
    );

    // Sign fix-up on the last step's output: quotient negative when the signs
    // differ, remainder follows the dividend. 0x80000000 / -1 negates back to
    // 0x80000000 in two's complement, which is the intended answer.
    assign w_quo_fix = (r_sign & (r_neg1 ^ r_neg2)) ? -w_quo_next : w_quo_next;
    assign w_rem_fix = (r_sign & r_neg1)            ? -w_rem_next : w_rem_next;

    // Controller and datapath. In DIVZERO r_quo holds the raw dividend so it
    // can be returned unchanged as the remainder. result is only written on
    // the transition into END, so it stays stable while busy or after annul.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_sign   <= 1'b0;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_result <= '0;
        end else if (r_state != IDLE && div_annul_i) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (div_start_i && !div_annul_i) begin
                        r_sign  <= div_sign;
                        r_neg1  <= w_neg1;
                        r_neg2  <= w_neg2;
                        r_count <= '0;
                        r_rem   <= '0;
                        if (div_op2 == '0) begin
                            r_quo   <= div_op1;
                            r_div   <= div_op2;
                            r_state <= DIVZERO;
                        end else begin
                            r_quo   <= w_mag1;
                            r_div   <= w_mag2;
                            r_state <= ON;
                        end
                    end
                end
                DIVZERO: begin
                    r_result <= {r_quo, DIV_ZERO_QUO};
                    r_state  <= END;
                end
                ON: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= w_quo_next;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == LAST) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_state  <= END;
                    end
                end
                END: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Status flags are straight decodes of the state register.
    assign result      = r_result;
    assign div_ready_o = (r_state == END);
    assign div_busy_o  = (r_state != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Directed, table-driven bench for div_unit plus hand-written sequences for
// annul, mid-flight reset and back-to-back starts. Outputs are sampled on the
// falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        div_sign;
    logic        div_start_i;
    logic        div_annul_i;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [63:0] result;
    logic        div_ready_o;
    logic        div_busy_o;

    int checks;
    int errors;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    div_unit #(.DATA_W(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .div_sign    (div_sign),
        .div_start_i (div_start_i),
        .div_annul_i (div_annul_i),
        .div_op1     (div_op1),
        .div_op2     (div_op2),
        .result      (result),
        .div_ready_o (div_ready_o),
        .div_busy_o  (div_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive a request at a falling edge, let E0 take it, then scramble the
    // operands and sign so a divider that re-samples them gives a wrong answer.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        div_sign    = sgn;
        div_op1     = a;
        div_op2     = b;
        div_start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_start_i = 1'b0;
        div_sign    = ~sgn;
        div_op1     = ~a;
        div_op2     = b + 32'd1;
    endtask

    // Count edges from E0 until ready, bounded. A stray start pulse in the
    // middle of the operation must be ignored.
    task automatic waitDone(output int n, output int busyCnt);
        n       = 0;
        busyCnt = 0;
        while (!div_ready_o && n < 40) begin
            if (div_busy_o) busyCnt++;
            div_start_i = (n == 3);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        if (div_busy_o) busyCnt++;
        div_start_i = 1'b0;
    endtask

    initial begin
        int          n;
        int          busyCnt;
        logic [63:0] lastRes;

        checks = 0;
        errors = 0;

        vecs[0]  = '{"u 100/7",          1'b0, 32'd100,       32'd7,         32'hE,         32'h2,         32};
        vecs[1]  = '{"s -7/2",           1'b1, 32'hFFFFFFF9,  32'h2,         32'hFFFFFFFD,  32'hFFFFFFFF,  32};
        vecs[2]  = '{"s 7/-2",           1'b1, 32'h7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'h1,         32};
        vecs[3]  = '{"u div0",           1'b0, 32'h1234,      32'h0,         32'hFFFFFFFF,  32'h1234,      1};
        vecs[4]  = '{"s min/-1",         1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'h0,         32};
        vecs[5]  = '{"u max/1",          1'b0, 32'hFFFFFFFF,  32'h1,         32'hFFFFFFFF,  32'h0,         32};
        vecs[6]  = '{"u fff9/2",         1'b0, 32'hFFFFFFF9,  32'h2,         32'h7FFFFFFC,  32'h1,         32};
        vecs[7]  = '{"s -7/-2",          1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'h3,         32'hFFFFFFFF,  32};
        vecs[8]  = '{"s div0 neg",       1'b1, 32'hFFFFFFF9,  32'h0,         32'hFFFFFFFF,  32'hFFFFFFF9,  1};
        vecs[9]  = '{"u 5/10",           1'b0, 32'd5,         32'd10,        32'h0,         32'h5,         32};
        vecs[10] = '{"u deadbeef/16",    1'b0, 32'hDEADBEEF,  32'h10,        32'h0DEADBEE,  32'hF,         32};
        vecs[11] = '{"s -100/7",         1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  32};

        resetn      = 1'b0;
        div_sign    = 1'b0;
        div_start_i = 1'b0;
        div_annul_i = 1'b0;
        div_op1     = '0;
        div_op2     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset result", result, 64'h0);
        checkOutput("reset ready", {63'h0, div_ready_o}, 64'h0);
        checkOutput("reset busy", {63'h0, div_busy_o}, 64'h0);

        // First request goes in on the very edge after reset release.
        resetn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b);
            checkOutput({vecs[i].name, " accept"}, {63'h0, div_busy_o}, 64'h1);
            waitDone(n, busyCnt);
            checkOutput({vecs[i].name, " latency"}, 64'(n), 64'(vecs[i].lat));
            checkOutput({vecs[i].name, " busy cycles"}, 64'(busyCnt), 64'(vecs[i].lat + 1));
            checkOutput({vecs[i].name, " result"}, result, {vecs[i].r, vecs[i].q});
            @(posedge clk);
            @(negedge clk);
            checkOutput({vecs[i].name, " ready pulse"}, {62'h0, div_ready_o, div_busy_o}, 64'h0);
            checkOutput({vecs[i].name, " result hold"}, result, {vecs[i].r, vecs[i].q});
        end
        lastRes = {vecs[11].r, vecs[11].q};

        // Annul after ten iterations: idle next cycle, no ready, result kept.
        applyStimulus(1'b0, 32'd100, 32'd7);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("annul busy before", {63'h0, div_busy_o}, 64'h1);
        div_annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_annul_i = 1'b0;
        checkOutput("annul state", {62'h0, div_ready_o, div_busy_o}, 64'h0);
        checkOutput("annul result", result, lastRes);

        // A new start is taken straight away after the annul.
        applyStimulus(1'b0, 32'd1000, 32'd9);
        checkOutput("post-annul accept", {63'h0, div_busy_o}, 64'h1);
        waitDone(n, busyCnt);
        checkOutput("post-annul latency", 64'(n), 64'd32);
        checkOutput("post-annul result", result, {32'd1, 32'd111});
        @(posedge clk);
        @(negedge clk);

        // Annul together with start in IDLE blocks the request.
        div_sign    = 1'b0;
        div_op1     = 32'd50;
        div_op2     = 32'd3;
        div_start_i = 1'b1;
        div_annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_start_i = 1'b0;
        div_annul_i = 1'b0;
        checkOutput("annul blocks start", {63'h0, div_busy_o}, 64'h0);

        // Reset in the middle of an operation clears everything.
        applyStimulus(1'b1, 32'hFFFFFF9C, 32'd7);
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
        end
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        checkOutput("midreset result", result, 64'h0);
        checkOutput("midreset flags", {62'h0, div_ready_o, div_busy_o}, 64'h0);

        // Start held through END is ignored there, then taken one cycle later.
        applyStimulus(1'b0, 32'd100, 32'd7);
        waitDone(n, busyCnt);
        checkOutput("b2b first result", result, {32'h2, 32'hE});
        div_sign    = 1'b0;
        div_op1     = 32'd50;
        div_op2     = 32'd3;
        div_start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("start in END ignored", {63'h0, div_busy_o}, 64'h0);
        checkOutput("b2b result hold", result, {32'h2, 32'hE});
        @(posedge clk);
        @(negedge clk);
        div_start_i = 1'b0;
        checkOutput("b2b accept", {63'h0, div_busy_o}, 64'h1);
        waitDone(n, busyCnt);
        checkOutput("b2b latency", 64'(n), 64'd32);
        checkOutput("b2b result", result, {32'd2, 32'd16});
        @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
